// File: rtl/soldier_move_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | soldier_move_controller_if                                         |
// | Frame/direction inputs, eraser/drawer handshakes, sprite position. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface soldier_move_controller_if;
  logic       frame_tick;
  logic       move_left;
  logic       move_right;
  logic       move_up;
  logic       move_down;
  logic       erase_go;
  logic       erase_done;
  logic       draw_go;
  logic       draw_done;
  logic [8:0] x_pos;
  logic [7:0] y_pos;
  logic       busy;
  logic       err;

  modport master (
    input  frame_tick, move_left, move_right, move_up, move_down,
    input  erase_done, draw_done,
    output erase_go, draw_go, x_pos, y_pos, busy, err
  );

  modport slave (
    output frame_tick, move_left, move_right, move_up, move_down,
    output erase_done, draw_done,
    input  erase_go, draw_go, x_pos, y_pos, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/soldier_move_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | soldier_move_controller                                            |
// | Per-frame sprite position update with erase-then-draw sequencing.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module soldier_move_controller #(
  parameter int X_INIT  = 0,
  parameter int Y_INIT  = 207,
  parameter int X_MAX   = 288,
  parameter int Y_MAX   = 207,
  parameter int STEP    = 4,
  parameter int TIMEOUT = 4095
) (
  input  wire logic                 clk,
  input  wire logic                 reset_n,
  soldier_move_controller_if.master bus
);

  localparam logic [2:0] S_INIT_REQ   = 3'd0;
  localparam logic [2:0] S_INIT_WAIT  = 3'd1;
  localparam logic [2:0] S_IDLE       = 3'd2;
  localparam logic [2:0] S_ERASE_REQ  = 3'd3;
  localparam logic [2:0] S_ERASE_WAIT = 3'd4;
  localparam logic [2:0] S_DRAW_REQ   = 3'd5;
  localparam logic [2:0] S_DRAW_WAIT  = 3'd6;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]     c_cnt_last = CW'(TIMEOUT - 1);
  localparam logic signed [9:0] c_step     = 10'(STEP);
  localparam logic signed [9:0] c_x_max    = 10'(X_MAX);
  localparam logic signed [9:0] c_y_max    = 10'(Y_MAX);

  logic [2:0]      r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [8:0]      r_x, w_nx;
  logic [7:0]      r_y, w_ny;
  logic            r_erase_go, r_draw_go, r_busy, r_err;
  logic signed [9:0] w_dx, w_dy, w_cx, w_cy;
  logic            w_move, w_expired, w_in_wait, w_done_match, w_abort;
  logic            w_erase_go, w_draw_go;

  // Candidate position: opposing requests cancel, results clamp to the screen.
  always_comb begin
    w_dx = '0;
    w_dy = '0;
    if (bus.move_left && !bus.move_right)      w_dx = -c_step;
    else if (bus.move_right && !bus.move_left) w_dx = c_step;
    if (bus.move_up && !bus.move_down)         w_dy = -c_step;
    else if (bus.move_down && !bus.move_up)    w_dy = c_step;
    w_cx = $signed({1'b0, r_x}) + w_dx;
    w_cy = $signed({2'b00, r_y}) + w_dy;
    if (w_cx[9])              w_nx = '0;
    else if (w_cx > c_x_max)  w_nx = c_x_max[8:0];
    else                      w_nx = w_cx[8:0];
    if (w_cy[9])              w_ny = '0;
    else if (w_cy > c_y_max)  w_ny = c_y_max[7:0];
    else                      w_ny = w_cy[7:0];
    w_move = (w_nx != r_x) || (w_ny != r_y);
  end

  assign w_expired = (r_cnt == c_cnt_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_INIT_REQ;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT_REQ:   w_next = S_INIT_WAIT;
      S_INIT_WAIT:  if (bus.draw_done || w_expired) w_next = S_IDLE;
      S_IDLE:       if (bus.frame_tick && w_move) w_next = S_ERASE_REQ;
      S_ERASE_REQ:  w_next = S_ERASE_WAIT;
      S_ERASE_WAIT: if (bus.erase_done) w_next = S_DRAW_REQ;
                    else if (w_expired) w_next = S_IDLE;
      S_DRAW_REQ:   w_next = S_DRAW_WAIT;
      S_DRAW_WAIT:  if (bus.draw_done || w_expired) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_erase_go   = (r_state == S_ERASE_REQ);
    w_draw_go    = (r_state == S_INIT_REQ) || (r_state == S_DRAW_REQ);
    w_in_wait    = 1'b0;
    w_done_match = 1'b0;
    case (r_state)
      S_INIT_WAIT, S_DRAW_WAIT: begin
        w_in_wait    = 1'b1;
        w_done_match = bus.draw_done;
      end
      S_ERASE_WAIT: begin
        w_in_wait    = 1'b1;
        w_done_match = bus.erase_done;
      end
      default: ;
    endcase
    w_abort = w_in_wait && !w_done_match && w_expired;
  end

  // Counter restarts on every state change, so each wait state begins at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x        <= 9'(X_INIT);
      r_y        <= 8'(Y_INIT);
      r_erase_go <= 1'b0;
      r_draw_go  <= 1'b0;
      r_busy     <= 1'b1;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_erase_go <= w_erase_go;
      r_draw_go  <= w_draw_go;
      r_busy     <= (w_next != S_IDLE);
      if (w_abort) r_err <= 1'b1;
      if (w_next != r_state) r_cnt <= '0;
      else if (w_in_wait)    r_cnt <= r_cnt + 1'b1;
      if (r_state == S_IDLE && bus.frame_tick && w_move) begin
        r_x <= w_nx;
        r_y <= w_ny;
      end
    end
  end

  assign bus.erase_go = r_erase_go;
  assign bus.draw_go  = r_draw_go;
  assign bus.x_pos    = r_x;
  assign bus.y_pos    = r_y;
  assign bus.busy     = r_busy;
  assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_soldier_move_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_soldier_move_controller                                         |
// | Directed checks of reset, moves, clamping, stray events, timeout.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_soldier_move_controller;

  localparam int TO = 4095;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   n_vec   = 0;
  int   n_err   = 0;
  int   n_erase = 0;
  int   n_draw  = 0;
  int   n_b_erase = 0;
  logic [2:0] b_ers = '0;
  logic [2:0] b_drs = '0;

  always #5 clk = ~clk;

  soldier_move_controller_if bus ();
  soldier_move_controller_if bus_b ();

  soldier_move_controller u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Second instance starts next to the right edge to exercise clamping.
  soldier_move_controller #(.X_INIT(286), .Y_INIT(2)) u_dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  always @(posedge clk) begin
    if (bus.erase_go)   n_erase   <= n_erase + 1;
    if (bus.draw_go)    n_draw    <= n_draw + 1;
    if (bus_b.erase_go) n_b_erase <= n_b_erase + 1;
    b_ers <= {b_ers[1:0], bus_b.erase_go};
    b_drs <= {b_drs[1:0], bus_b.draw_go};
  end
  assign bus_b.erase_done = b_ers[2];
  assign bus_b.draw_done  = b_drs[2];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic l, input logic r, input logic u, input logic d);
    bus.move_left = l; bus.move_right = r; bus.move_up = u; bus.move_down = d;
    bus.frame_tick = 1'b1;
    step(1);
    bus.frame_tick = 1'b0;
    bus.move_left = 0; bus.move_right = 0; bus.move_up = 0; bus.move_down = 0;
  endtask

  task automatic tick_b(input logic l, input logic r, input logic u, input logic d);
    bus_b.move_left = l; bus_b.move_right = r; bus_b.move_up = u; bus_b.move_down = d;
    bus_b.frame_tick = 1'b1;
    step(1);
    bus_b.frame_tick = 1'b0;
    bus_b.move_left = 0; bus_b.move_right = 0; bus_b.move_up = 0; bus_b.move_down = 0;
  endtask

  task automatic wait_idle_b(input string tag);
    int k = 0;
    while (bus_b.busy && k < 50) begin
      step(1);
      k++;
    end
    chk(tag, int'(bus_b.busy), 0);
  endtask

  task automatic pulse_erase_done();
    bus.erase_done = 1'b1;
    step(1);
    bus.erase_done = 1'b0;
  endtask

  task automatic pulse_draw_done();
    bus.draw_done = 1'b1;
    step(1);
    bus.draw_done = 1'b0;
  endtask

  initial begin
    bus.frame_tick = 0; bus.move_left = 0; bus.move_right = 0;
    bus.move_up = 0; bus.move_down = 0; bus.erase_done = 0; bus.draw_done = 0;
    bus_b.frame_tick = 0; bus_b.move_left = 0; bus_b.move_right = 0;
    bus_b.move_up = 0; bus_b.move_down = 0;

    #1 reset_n = 1'b0;
    #2;
    chk("rst_x", int'(bus.x_pos), 0);
    chk("rst_y", int'(bus.y_pos), 207);
    chk("rst_busy", int'(bus.busy), 1);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_draw_go", int'(bus.draw_go), 0);
    chk("rst_erase_go", int'(bus.erase_go), 0);
    step(2);
    reset_n = 1'b1;

    // Initial paint: one draw pulse, no erase.
    step(1);
    chk("init_draw_go", int'(bus.draw_go), 1);
    chk("init_busy", int'(bus.busy), 1);
    step(1);
    chk("init_draw_go_fall", int'(bus.draw_go), 0);
    step(3);
    chk("init_wait_busy", int'(bus.busy), 1);
    pulse_draw_done();
    chk("init_idle_busy", int'(bus.busy), 0);
    chk("init_draws", n_draw, 1);
    chk("init_erases", n_erase, 0);
    chk("init_pos_x", int'(bus.x_pos), 0);

    // Left+down at (0,207) clamps to the same spot: no sequence.
    tick(1, 0, 0, 1);
    chk("clamp_busy", int'(bus.busy), 0);
    step(2);
    chk("clamp_erases", n_erase, 0);
    chk("clamp_x", int'(bus.x_pos), 0);
    chk("clamp_y", int'(bus.y_pos), 207);

    // Right move with a slow eraser.
    tick(0, 1, 0, 0);
    chk("m1_x", int'(bus.x_pos), 4);
    chk("m1_y", int'(bus.y_pos), 207);
    chk("m1_busy", int'(bus.busy), 1);
    chk("m1_erase_go_pre", int'(bus.erase_go), 0);
    step(1);
    chk("m1_erase_go", int'(bus.erase_go), 1);
    step(1);
    chk("m1_erase_go_fall", int'(bus.erase_go), 0);
    step(1024);
    pulse_erase_done();
    chk("m1_draw_go_pre", int'(bus.draw_go), 0);
    step(1);
    chk("m1_draw_go", int'(bus.draw_go), 1);
    step(1);
    chk("m1_draw_go_fall", int'(bus.draw_go), 0);
    step(3);
    pulse_draw_done();
    chk("m1_idle", int'(bus.busy), 0);
    chk("m1_erases", n_erase, 1);
    chk("m1_draws", n_draw, 2);

    // Up move; frame ticks and stray draw_done during ERASE_WAIT are ignored.
    tick(0, 0, 1, 0);
    chk("m2_y", int'(bus.y_pos), 203);
    step(2);
    for (int i = 0; i < 3; i++) begin
      bus.move_right = 1'b1;
      bus.frame_tick = 1'b1;
      step(1);
      bus.frame_tick = 1'b0;
      step(1);
    end
    pulse_draw_done();
    bus.move_right = 1'b0;
    step(2);
    chk("m2_stray_x", int'(bus.x_pos), 4);
    chk("m2_stray_y", int'(bus.y_pos), 203);
    chk("m2_stray_busy", int'(bus.busy), 1);
    chk("m2_stray_draws", n_draw, 2);
    bus.erase_done = 1'b1; bus.frame_tick = 1'b1; bus.move_left = 1'b1;
    step(1);
    bus.erase_done = 1'b0; bus.frame_tick = 1'b0; bus.move_left = 1'b0;
    chk("m2_same_cycle_x", int'(bus.x_pos), 4);
    step(1);
    chk("m2_draw_go", int'(bus.draw_go), 1);
    step(2);
    pulse_draw_done();
    chk("m2_idle", int'(bus.busy), 0);
    chk("m2_draws", n_draw, 3);

    // Eraser never answers: abort exactly TO cycles after ERASE_WAIT entry.
    tick(0, 0, 0, 1);
    chk("to_y", int'(bus.y_pos), 207);
    step(1);
    chk("to_erase_go", int'(bus.erase_go), 1);
    step(TO - 1);
    chk("to_err_early", int'(bus.err), 0);
    chk("to_busy_early", int'(bus.busy), 1);
    step(1);
    chk("to_err", int'(bus.err), 1);
    chk("to_busy", int'(bus.busy), 0);

    // Normal operation continues with err sticky.
    tick(0, 1, 0, 0);
    chk("m4_x", int'(bus.x_pos), 8);
    step(1);
    chk("m4_erase_go", int'(bus.erase_go), 1);
    step(5);
    pulse_erase_done();
    step(4);
    pulse_draw_done();
    chk("m4_idle", int'(bus.busy), 0);
    chk("m4_err_sticky", int'(bus.err), 1);

    // Clamping near the right and top edges on the second instance.
    chk("b_init_x", int'(bus_b.x_pos), 286);
    chk("b_init_y", int'(bus_b.y_pos), 2);
    chk("b_init_busy", int'(bus_b.busy), 0);
    tick_b(0, 1, 1, 0);
    chk("b1_x", int'(bus_b.x_pos), 288);
    chk("b1_y", int'(bus_b.y_pos), 0);
    wait_idle_b("b1_idle");
    tick_b(1, 1, 1, 0);
    chk("b2_busy", int'(bus_b.busy), 0);
    step(2);
    chk("b2_erases", n_b_erase, 1);
    chk("b2_y", int'(bus_b.y_pos), 0);
    tick_b(0, 1, 0, 1);
    chk("b3_x", int'(bus_b.x_pos), 288);
    chk("b3_y", int'(bus_b.y_pos), 4);
    wait_idle_b("b3_idle");
    tick_b(0, 1, 1, 1);
    chk("b4_busy", int'(bus_b.busy), 0);
    chk("b4_y", int'(bus_b.y_pos), 4);

    // Asynchronous reset in DRAW_WAIT.
    tick(1, 0, 0, 0);
    chk("m5_x", int'(bus.x_pos), 4);
    step(3);
    pulse_erase_done();
    step(1);
    chk("m5_draw_go", int'(bus.draw_go), 1);
    step(2);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_x", int'(bus.x_pos), 0);
    chk("arst_y", int'(bus.y_pos), 207);
    chk("arst_busy", int'(bus.busy), 1);
    chk("arst_err", int'(bus.err), 0);
    chk("arst_draw_go", int'(bus.draw_go), 0);
    step(2);
    reset_n = 1'b1;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
